// File: rtl/eth_frame_loop_pkg.sv
// Shared definitions for the frame-loop path: control-word layout, FSM encoding
// and the decoded control-word struct used by both the FIFO writer and the TX replay.
package eth_frame_loop_pkg;

    localparam int FCS_INVALID_BIT = 0;
    localparam int DROP_FRAME_BIT  = 1;
    localparam int CSUM_POS_LSB    = 2;
    localparam int CSUM_POS_W      = 15;
    localparam int CSUM_VAL_LSB    = 17;
    localparam int CSUM_VAL_W      = 16;
    localparam int CTL_W           = 40;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FWD  = 2'd1;
    localparam state_t ST_DROP = 2'd2;

    typedef struct packed {
        logic [CSUM_VAL_W-1:0] csum_val;
        logic [CSUM_POS_W-1:0] csum_pos;
        logic                  drop_frame;
        logic                  fcs_invalid;
    } ctl_word_t;

    function automatic ctl_word_t decode_ctl(input logic [CTL_W-1:0] word);
        ctl_word_t c;
        c.fcs_invalid = word[FCS_INVALID_BIT];
        c.drop_frame  = word[DROP_FRAME_BIT];
        c.csum_pos    = word[CSUM_POS_LSB +: CSUM_POS_W];
        c.csum_val    = word[CSUM_VAL_LSB +: CSUM_VAL_W];
        return c;
    endfunction

endpackage

// File: rtl/eth_frame_loop_tx_patch.sv
// Combinational checksum patch: overwrites the two bytes at csum_pos/csum_pos+1
// with csum_val (big-endian); csum_pos == 0 disables the patch.
module eth_frame_loop_tx_patch
    import eth_frame_loop_pkg::*;
(
    input  logic [15:0]           byte_idx,
    input  logic [CSUM_POS_W-1:0] csum_pos,
    input  logic [CSUM_VAL_W-1:0] csum_val,
    input  logic [7:0]            din,
    output logic [7:0]            dout
);

    logic [15:0] pos_hi;
    logic [15:0] pos_lo;
    logic        patch_en;

    // csum_pos is 15 bits, so the 16-bit +1 below can never wrap.
    assign pos_hi   = {1'b0, csum_pos};
    assign pos_lo   = pos_hi + 16'd1;
    assign patch_en = (csum_pos != '0);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves dout unassigned (no latch).
        dout = din;
        if (patch_en && byte_idx == pos_hi)
            dout = csum_val[15:8];
        else if (patch_en && byte_idx == pos_lo)
            dout = csum_val[7:0];
    end

endmodule

// File: rtl/eth_frame_loop_tx.sv
// Replays looped frames to the TX MAC, dropping or checksum-patching them per control word.
// Optional macro ETH_LOOP_TX_FWD_BAD_FCS_EN forwards FCS-invalid frames with tuser on tlast.
module eth_frame_loop_tx
    import eth_frame_loop_pkg::*;
#(
    parameter int C_COUNTER_WIDTH = 32
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 s_axis_frame_tdata,
    input  logic                       s_axis_frame_tlast,
    input  logic                       s_axis_frame_tvalid,
    output logic                       s_axis_frame_tready,
    input  logic [CTL_W-1:0]           s_axis_ctl_tdata,
    input  logic                       s_axis_ctl_tvalid,
    output logic                       s_axis_ctl_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [C_COUNTER_WIDTH-1:0] count_tx,
    output logic [C_COUNTER_WIDTH-1:0] count_drop
);

    state_t      state;
    ctl_word_t   ctl_dec;
    ctl_word_t   ctl_q;
    logic [15:0] byte_cnt;
    logic [7:0]  patched;
    logic        frame_hs;
    logic        ctl_hs;
    logic        fwd_hs;
    logic        go_drop;
    logic        unused_ctl;

    assign ctl_dec = decode_ctl(s_axis_ctl_tdata);

`ifdef ETH_LOOP_TX_FWD_BAD_FCS_EN
    assign go_drop = ctl_dec.drop_frame;
`else
    assign go_drop = ctl_dec.drop_frame | ctl_dec.fcs_invalid;
`endif

    assign unused_ctl = ^{s_axis_ctl_tdata[CTL_W-1:CSUM_VAL_LSB+CSUM_VAL_W],
                          ctl_q.drop_frame, ctl_q.fcs_invalid};

    assign s_axis_ctl_tready = (state == ST_IDLE);

    always_comb begin
        s_axis_frame_tready = 1'b0;
        case (state)
            ST_FWD:  s_axis_frame_tready = ~m_axis_tvalid | m_axis_tready;
            ST_DROP: s_axis_frame_tready = 1'b1;
            default: s_axis_frame_tready = 1'b0;
        endcase
    end

    assign ctl_hs   = s_axis_ctl_tvalid & s_axis_ctl_tready;
    assign frame_hs = s_axis_frame_tvalid & s_axis_frame_tready;
    assign fwd_hs   = frame_hs & (state == ST_FWD);

    eth_frame_loop_tx_patch u_patch (
        .byte_idx (byte_cnt),
        .csum_pos (ctl_q.csum_pos),
        .csum_val (ctl_q.csum_val),
        .din      (s_axis_frame_tdata),
        .dout     (patched)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state      <= ST_IDLE;
            ctl_q      <= '0;
            byte_cnt   <= '0;
            count_tx   <= '0;
            count_drop <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl_hs) begin
                        ctl_q    <= ctl_dec;
                        byte_cnt <= '0;
                        state    <= go_drop ? ST_DROP : ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (frame_hs) begin
                        if (byte_cnt != 16'hFFFF)
                            byte_cnt <= byte_cnt + 16'd1;
                        if (s_axis_frame_tlast) begin
                            count_tx <= count_tx + 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (frame_hs && s_axis_frame_tlast) begin
                        count_drop <= count_drop + 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Single-stage output register; a new byte may load in the same cycle the old one drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (fwd_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= patched;
            m_axis_tlast  <= s_axis_frame_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef ETH_LOOP_TX_FWD_BAD_FCS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            m_axis_tuser <= 1'b0;
        else if (fwd_hs)
            m_axis_tuser <= s_axis_frame_tlast & ctl_q.fcs_invalid;
    end
`else
    assign m_axis_tuser = 1'b0;
`endif

endmodule

// File: tb/tb_eth_frame_loop_tx.sv
// Self-checking bench for eth_frame_loop_tx: directed cases plus randomized frames
// with backpressure, checked against a queue-based frame-level reference model.
`timescale 1ns/1ps
module tb_eth_frame_loop_tx;

`ifdef ETH_LOOP_TX_FWD_BAD_FCS_EN
    localparam bit FWD_BAD_FCS = 1'b1;
`else
    localparam bit FWD_BAD_FCS = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_frame_tdata = '0;
    logic        s_axis_frame_tlast = 1'b0;
    logic        s_axis_frame_tvalid = 1'b0;
    logic        s_axis_frame_tready;
    logic [39:0] s_axis_ctl_tdata = '0;
    logic        s_axis_ctl_tvalid = 1'b0;
    logic        s_axis_ctl_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] count_tx;
    logic [31:0] count_drop;

    eth_frame_loop_tx #(.C_COUNTER_WIDTH(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .s_axis_frame_tdata  (s_axis_frame_tdata),
        .s_axis_frame_tlast  (s_axis_frame_tlast),
        .s_axis_frame_tvalid (s_axis_frame_tvalid),
        .s_axis_frame_tready (s_axis_frame_tready),
        .s_axis_ctl_tdata    (s_axis_ctl_tdata),
        .s_axis_ctl_tvalid   (s_axis_ctl_tvalid),
        .s_axis_ctl_tready   (s_axis_ctl_tready),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tuser        (m_axis_tuser),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .count_tx            (count_tx),
        .count_drop          (count_drop)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    beat_t       src_q[$];
    logic [39:0] ctl_q[$];
    beat_t       exp_q[$];
    beat_t       obs_q[$];
    int          obs_cyc[$];
    int          gap_pct = 0;
    int          rdy_pct = 100;
    int          acc_cnt = 0;
    int          cyc = 0;
    longint      exp_tx = 0;
    longint      exp_drop = 0;
    bit          hold_pending = 1'b0;
    beat_t       hold_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Loop-FIFO model on the input side: pops whatever the DUT accepted at this edge.
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (s_axis_frame_tvalid && s_axis_frame_tready) begin
                void'(src_q.pop_front());
                acc_cnt++;
            end
            if (s_axis_ctl_tvalid && s_axis_ctl_tready)
                void'(ctl_q.pop_front());
        end
    end

    // Drive inputs and watch the output handshake half a cycle away from the active edge.
    always @(negedge clk) begin
        s_axis_frame_tvalid = (src_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        if (src_q.size() > 0) begin
            s_axis_frame_tdata = src_q[0].data;
            s_axis_frame_tlast = src_q[0].last;
        end
        s_axis_ctl_tvalid = (ctl_q.size() > 0);
        if (ctl_q.size() > 0)
            s_axis_ctl_tdata = ctl_q[0];
        m_axis_tready = ($urandom_range(99) < rdy_pct);
        if (rst_n) begin
            if (hold_pending) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, hold_beat);
            end
            hold_pending = m_axis_tvalid && !m_axis_tready;
            hold_beat    = '{m_axis_tdata, m_axis_tlast, m_axis_tuser};
            if (m_axis_tvalid && m_axis_tready) begin
                obs_q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser});
                obs_cyc.push_back(cyc);
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    function automatic logic [39:0] mk_ctl(input bit fcs, input bit drop,
                                           input logic [14:0] pos, input logic [15:0] val);
        return {7'b0, val, pos, drop, fcs};
    endfunction

    // Reference model: expected MAC beats follow directly from the frame rules.
    task automatic send_frame(input int len, input logic [39:0] ctl, input bit seq);
        int          pos;
        logic [15:0] val;
        bit          fwd;
        logic [7:0]  b;
        pos = int'(ctl[16:2]);
        val = ctl[32:17];
        fwd = !ctl[1] && (!ctl[0] || FWD_BAD_FCS);
        for (int i = 0; i < len; i++) begin
            b = seq ? 8'(i) : 8'($urandom);
            src_q.push_back('{b, (i == len - 1), 1'b0});
            if (pos != 0 && i == pos)          b = val[15:8];
            else if (pos != 0 && i == pos + 1) b = val[7:0];
            if (fwd) exp_q.push_back('{b, (i == len - 1), (i == len - 1) && ctl[0]});
        end
        ctl_q.push_back(ctl);
        if (fwd) exp_tx++;
        else     exp_drop++;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((src_q.size() != 0 || ctl_q.size() != 0 || obs_q.size() < exp_q.size()
                || m_axis_tvalid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain_in_time", (n < budget), 1);
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_beats"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_count_tx"}, count_tx, exp_tx);
        check({tag, "_count_drop"}, count_drop, exp_drop);
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        src_q.delete();
        ctl_q.delete();
        @(posedge clk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_count_tx", count_tx, 0);
        check("rst_count_drop", count_drop, 0);
        check("rst_ctl_tready", s_axis_ctl_tready, 1);
        check("rst_frame_tready", s_axis_frame_tready, 0);
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
        exp_tx   = 0;
        exp_drop = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int          len;
        int          n;
        logic [14:0] pos;
        do_reset();

        // Straight forwarding at full rate, one byte per cycle.
        send_frame(64, 40'h0, 1'b1);
        wait_drain(2000);
        if (obs_cyc.size() >= 64)
            check("fwd_throughput", obs_cyc[63] - obs_cyc[0], 63);
        else
            check("fwd_throughput_beats", obs_cyc.size(), 64);
        compare_out("fwd");

        send_frame(60, mk_ctl(1'b0, 1'b0, 15'd24, 16'hBEEF), 1'b1);
        wait_drain(2000);
        compare_out("patch");

        // Overflow frame, then a clean frame that must come through untouched.
        send_frame(40, mk_ctl(1'b0, 1'b1, 15'd0, 16'h0), 1'b1);
        send_frame(20, 40'h0, 1'b1);
        wait_drain(2000);
        check("drop_fifo_drained", src_q.size(), 0);
        compare_out("drop");

        send_frame(30, mk_ctl(1'b1, 1'b0, 15'd0, 16'h0), 1'b1);
        send_frame(10, 40'h0, 1'b1);
        wait_drain(2000);
        compare_out("bad_fcs");

        // Patch boundaries: split by tlast, beyond the frame, and disabled by pos 0.
        send_frame(16, mk_ctl(1'b0, 1'b0, 15'd15, 16'h1234), 1'b1);
        send_frame(16, mk_ctl(1'b0, 1'b0, 15'd40, 16'h5678), 1'b1);
        send_frame(16, mk_ctl(1'b0, 1'b0, 15'd0,  16'hA5A5), 1'b1);
        send_frame(3,  mk_ctl(1'b0, 1'b0, 15'd1,  16'hC3D2), 1'b1);
        send_frame(1,  40'h0, 1'b0);
        wait_drain(2000);
        compare_out("patch_edge");

        // Randomized frames under 30% output duty and input bubbles.
        rdy_pct = 30;
        gap_pct = 10;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(70, 1);
            pos = ($urandom_range(3) == 0) ? 15'd0 : 15'($urandom_range(len + 2, 1));
            send_frame(len, mk_ctl(($urandom_range(4) == 0), ($urandom_range(4) == 0),
                                   pos, 16'($urandom)), 1'b0);
        end
        wait_drain(60000);
        compare_out("random");

        // Reset in the middle of a frame, then recovery.
        rdy_pct = 100;
        gap_pct = 0;
        acc_cnt = 0;
        send_frame(64, 40'h0, 1'b1);
        n = 0;
        while (acc_cnt < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reset_mid_reached", (acc_cnt >= 10), 1);
        do_reset();
        send_frame(64, 40'h0, 1'b1);
        send_frame(25, mk_ctl(1'b0, 1'b0, 15'd5, 16'h0F0F), 1'b0);
        wait_drain(2000);
        compare_out("after_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
